// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the two-requester APB master arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface apb_master_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic [1:0]        req;
   logic              wr0;
   logic              wr1;
   logic              tgt0;
   logic              tgt1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        done;
   logic [1:0]        err;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   logic [1:0]        psel;
   logic              penable;
   logic              pwrite;
   logic [1:0]        pstrb;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr_rm;
   logic              pslverr_icn;

   modport master (
      input  req, wr0, wr1, tgt0, tgt1, addr0, addr1, wdata0, wdata1,
      output done, err, rdata, busy,
      output psel, penable, pwrite, pstrb, paddr, pwdata,
      input  pready, prdata, pslverr_rm, pslverr_icn
   );

   modport slave (
      output req, wr0, wr1, tgt0, tgt1, addr0, addr1, wdata0, wdata1,
      input  done, err, rdata, busy,
      input  psel, penable, pwrite, pstrb, paddr, pwdata,
      output pready, prdata, pslverr_rm, pslverr_icn
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between two requesters,
// with SETUP/ACCESS sequencing, one-cycle done/err response and PREADY timeout.
module apb_master_arbiter #(
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   apb_master_arbiter_if.master  bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT != 0);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              gnt;
   logic              rr_ptr;
   logic [1:0]        done_q;
   logic [1:0]        err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              busy_q;
   logic [1:0]        psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [1:0]        pstrb_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;

   // On a tie rr_ptr names the requester that wins; it points away from the last one served.
   logic              gnt_sel;
   logic              sel_wr;
   logic              sel_tgt;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        gnt_hot;
   logic              slverr;

   assign gnt_sel   = (bus.req == 2'b11) ? rr_ptr : bus.req[1];
   assign sel_wr    = gnt_sel ? bus.wr1    : bus.wr0;
   assign sel_tgt   = gnt_sel ? bus.tgt1   : bus.tgt0;
   assign sel_addr  = gnt_sel ? bus.addr1  : bus.addr0;
   assign sel_wdata = gnt_sel ? bus.wdata1 : bus.wdata0;
   assign gnt_hot   = gnt ? 2'b10 : 2'b01;
   assign slverr    = psel_q[1] ? bus.pslverr_icn : bus.pslverr_rm;

   // NOTE: every register, including rdata and the APB address/data, takes the async
   //       reset so a reset mid-transfer drops the bus and never leaves a stale done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         gnt       <= 1'b0;
         rr_ptr    <= 1'b0;
         done_q    <= 2'b00;
         err_q     <= 2'b00;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
         psel_q    <= 2'b00;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pstrb_q   <= 2'b00;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         // NOTE: non-blocking only, so every branch reads the pre-edge register values.
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  gnt       <= gnt_sel;
                  paddr_q   <= sel_addr;
                  pwdata_q  <= sel_wdata;
                  pwrite_q  <= sel_wr;
                  pstrb_q   <= {2{sel_wr}};
                  psel_q    <= sel_tgt ? 2'b10 : 2'b01;
                  penable_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               cnt       <= '0;
               state     <= ACCESS;
            end
            ACCESS: begin
               // pready on the limit cycle still completes normally.
               if (bus.pready) begin
                  done_q    <= gnt_hot;
                  err_q     <= slverr ? gnt_hot : 2'b00;
                  if (!pwrite_q) rdata_q <= bus.prdata;
                  psel_q    <= 2'b00;
                  penable_q <= 1'b0;
                  state     <= RESP;
               end else if (TO_EN && cnt == LIMIT) begin
                  done_q    <= gnt_hot;
                  err_q     <= gnt_hot;
                  if (!pwrite_q) rdata_q <= '0;
                  psel_q    <= 2'b00;
                  penable_q <= 1'b0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               done_q <= 2'b00;
               err_q  <= 2'b00;
               rr_ptr <= ~gnt;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.done    = done_q;
   assign bus.err     = err_q;
   assign bus.rdata   = rdata_q;
   assign bus.busy    = busy_q;
   assign bus.psel    = psel_q;
   assign bus.penable = penable_q;
   assign bus.pwrite  = pwrite_q;
   assign bus.pstrb   = pstrb_q;
   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a vector table of single transfers plus
// hand sequences for back-to-back round robin, PREADY timeout and mid-transfer reset.
module tb_apb_master_arbiter;
   logic clk;
   logic reset_n;
   int   tests;
   int   failed;

   apb_master_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

   apb_master_arbiter #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req;
      logic        wr0;
      logic        wr1;
      logic        tgt0;
      logic        tgt1;
      logic [19:0] addr0;
      logic [19:0] addr1;
      logic [15:0] wdata0;
      logic [15:0] wdata1;
      int          wait_n;
      logic [15:0] prdata;
      logic        slverr_rm;
      logic        slverr_icn;
      logic [1:0]  exp_psel;
      logic [1:0]  exp_pstrb;
      logic [1:0]  exp_done;
      logic [1:0]  exp_err;
      logic        exp_pwrite;
      logic [19:0] exp_paddr;
      logic [15:0] exp_pwdata;
      logic [15:0] exp_rdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req = 2'b00; bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.tgt0 = 1'b0; bus.tgt1 = 1'b0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus.pready = 1'b0; bus.prdata = '0; bus.pslverr_rm = 1'b0; bus.pslverr_icn = 1'b0;
   endtask

   // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the following IDLE.
   task automatic run_txn(input vec_t v, input string tag);
      bus.req = v.req; bus.wr0 = v.wr0; bus.wr1 = v.wr1; bus.tgt0 = v.tgt0; bus.tgt1 = v.tgt1;
      bus.addr0 = v.addr0; bus.addr1 = v.addr1; bus.wdata0 = v.wdata0; bus.wdata1 = v.wdata1;
      bus.pready = 1'b0;
      @(posedge clk); #1;
      check({tag, " setup psel"},    bus.psel,    v.exp_psel);
      check({tag, " setup penable"}, bus.penable, 0);
      check({tag, " setup paddr"},   bus.paddr,   v.exp_paddr);
      check({tag, " setup pwdata"},  bus.pwdata,  v.exp_pwdata);
      check({tag, " setup pwrite"},  bus.pwrite,  v.exp_pwrite);
      check({tag, " setup pstrb"},   bus.pstrb,   v.exp_pstrb);
      check({tag, " setup busy"},    bus.busy,    1);
      @(posedge clk); #1;
      check({tag, " access penable"}, bus.penable, 1);
      check({tag, " access psel"},    bus.psel,    v.exp_psel);
      bus.prdata = v.prdata; bus.pslverr_rm = v.slverr_rm; bus.pslverr_icn = v.slverr_icn;
      bus.pready = (v.wait_n == 0);
      for (int i = 0; i < v.wait_n; i++) begin
         @(posedge clk); #1;
         check({tag, " wait penable"}, bus.penable, 1);
         check({tag, " wait done"},    bus.done,    0);
         bus.pready = (i == v.wait_n - 1);
      end
      @(posedge clk); #1;
      bus.pready = 1'b0; bus.pslverr_rm = 1'b0; bus.pslverr_icn = 1'b0; bus.req = 2'b00;
      check({tag, " resp done"},    bus.done,    v.exp_done);
      check({tag, " resp err"},     bus.err,     v.exp_err);
      check({tag, " resp rdata"},   bus.rdata,   v.exp_rdata);
      check({tag, " resp psel"},    bus.psel,    0);
      check({tag, " resp penable"}, bus.penable, 0);
      @(posedge clk); #1;
      check({tag, " idle done"},  bus.done,  0);
      check({tag, " idle busy"},  bus.busy,  0);
      check({tag, " idle pstrb"}, bus.pstrb, v.exp_pstrb);
   endtask

   vec_t vecs[6];
   vec_t post_rst;

   initial begin
      tests  = 0;
      failed = 0;
      reset_n = 1'b0;
      idle_inputs();

      // Fields: req wr0 wr1 tgt0 tgt1 addr0 addr1 wdata0 wdata1 wait prdata err_rm err_icn |
      //         psel pstrb done err pwrite paddr pwdata rdata
      vecs[0] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 20'h00000, 16'h0000, 16'h0000, 0,
                  16'hBEEF, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 20'h00010, 16'h0000, 16'hBEEF};
      vecs[1] = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00000, 20'h0ABCD, 16'h0000, 16'h1234, 3,
                  16'hDEAD, 1'b0, 1'b1, 2'b10, 2'b11, 2'b10, 2'b10, 1'b1, 20'h0ABCD, 16'h1234, 16'hBEEF};
      vecs[2] = '{2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 20'hFFFFF, 20'h00000, 16'hA5A5, 16'h0000, 1,
                  16'h1111, 1'b1, 1'b0, 2'b10, 2'b11, 2'b01, 2'b00, 1'b1, 20'hFFFFF, 16'hA5A5, 16'hBEEF};
      vecs[3] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 20'h12345, 16'h0000, 16'hCCCC, 2,
                  16'h0F0F, 1'b1, 1'b0, 2'b01, 2'b00, 2'b10, 2'b10, 1'b0, 20'h12345, 16'hCCCC, 16'h0F0F};
      vecs[4] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00001, 20'h00002, 16'h3333, 16'h2222, 0,
                  16'h7777, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 20'h00001, 16'h3333, 16'h7777};
      vecs[5] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00001, 20'h00002, 16'h3333, 16'h2222, 0,
                  16'h7777, 1'b0, 1'b1, 2'b10, 2'b11, 2'b10, 2'b10, 1'b1, 20'h00002, 16'h2222, 16'h7777};
      post_rst = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00000, 20'h00044, 16'h0000, 16'h0000, 0,
                  16'h9999, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 20'h00044, 16'h0000, 16'h9999};

      repeat (2) @(posedge clk);
      #1;
      check("reset psel",    bus.psel,    0);
      check("reset penable", bus.penable, 0);
      check("reset done",    bus.done,    0);
      check("reset err",     bus.err,     0);
      check("reset busy",    bus.busy,    0);
      check("reset rdata",   bus.rdata,   0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Both requesters held: grants alternate with a 4-cycle period.
      bus.req = 2'b11; bus.wr0 = 1'b1; bus.wr1 = 1'b1; bus.tgt0 = 1'b0; bus.tgt1 = 1'b1;
      bus.addr0 = 20'h00100; bus.addr1 = 20'h00200; bus.wdata0 = 16'hAAAA; bus.wdata1 = 16'h5555;
      bus.pready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("rr%0d psel", k),   bus.psel,   (k % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("rr%0d pwdata", k), bus.pwdata, (k % 2 == 0) ? 16'hAAAA : 16'h5555);
         check($sformatf("rr%0d pstrb", k),  bus.pstrb,  2'b11);
         @(posedge clk); #1;
         @(posedge clk); #1;
         check($sformatf("rr%0d done", k), bus.done, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k == 3) bus.req = 2'b00;
         @(posedge clk); #1;
         check($sformatf("rr%0d idle done", k), bus.done, 0);
      end
      idle_inputs();

      // Read with pready never asserted: abort after exactly 4 ACCESS cycles.
      bus.req = 2'b01; bus.wr0 = 1'b0; bus.tgt0 = 1'b1; bus.addr0 = 20'h00333;
      @(posedge clk); #1;
      check("to setup psel", bus.psel, 2'b10);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("to access%0d penable", i), bus.penable, 1);
         check($sformatf("to access%0d done", i),    bus.done,    0);
      end
      @(posedge clk); #1;
      bus.req = 2'b00;
      check("to resp done",    bus.done,    2'b01);
      check("to resp err",     bus.err,     2'b01);
      check("to resp rdata",   bus.rdata,   16'h0000);
      check("to resp psel",    bus.psel,    0);
      check("to resp penable", bus.penable, 0);
      @(posedge clk); #1;
      idle_inputs();

      // Reset asserted during ACCESS clears outputs without an edge and emits no done.
      bus.req = 2'b01; bus.wr0 = 1'b1; bus.tgt0 = 1'b0; bus.addr0 = 20'h00055; bus.wdata0 = 16'h6666;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst pre penable", bus.penable, 1);
      #2;
      reset_n = 1'b0;
      bus.req = 2'b00;
      #1;
      check("rst psel",    bus.psel,    0);
      check("rst penable", bus.penable, 0);
      check("rst busy",    bus.busy,    0);
      check("rst paddr",   bus.paddr,   0);
      check("rst pwdata",  bus.pwdata,  0);
      check("rst pstrb",   bus.pstrb,   0);
      check("rst pwrite",  bus.pwrite,  0);
      @(posedge clk); #1;
      check("rst hold done", bus.done, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      run_txn(post_rst, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
